pic_inta_sequencer: RTL and testbench

Clocked interrupt-acknowledge sequencer for the 8259-style interrupt controller. It sits between the IRR/IMR registers, the ICW/OCW register file and the data bus buffer. It decides when to raise INT, picks the winning level under fully nested or rotating priority, and owns the ISR. It also runs the two-pulse INTA sequence that places the 8086-mode vector on the bus, and executes EOI commands from OCW2.

---
 rtl/pic_inta_sequencer_pkg.sv | 31 +++
 rtl/pic_inta_sequencer_priority_resolver.sv | 33 +++
 rtl/pic_inta_sequencer.sv | 142 ++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types and constants for the 8259-style INTA sequencer.
// Levels, FSM states, OCW2 command codes and priority helper functions live here.
package pic_pkg;

  localparam int NUM_LEVELS = 8;
  localparam int LVL_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_t;

  // OCW2 {R, SL, EOI}
  localparam logic [2:0] EOI_NS  = 3'b001;
  localparam logic [2:0] EOI_SP  = 3'b011;
  localparam logic [2:0] ROT_NS  = 3'b101;
  localparam logic [2:0] ROT_SP  = 3'b111;
  localparam logic [2:0] SET_PRI = 3'b110;

  // 0 is the highest rank; the level just after lp ranks first
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                 input logic [LVL_W-1:0] lp);
    return lvl - lp - 3'd1;
  endfunction

  function automatic logic [NUM_LEVELS-1:0] onehot(input logic [LVL_W-1:0] lvl);
    return NUM_LEVELS'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_priority_resolver.sv
// Combinational rotating-priority resolver: finds the highest-ranked set bit
// of req, where level (lp+1) mod 8 ranks first.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] req,
  input  logic [LVL_W-1:0]      lp,
  output logic                  valid,
  output logic [LVL_W-1:0]      level
);

  logic [NUM_LEVELS-1:0] rot;
  logic [LVL_W-1:0]      off;

  // rot[0] is the request that currently ranks highest
  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_rot
    assign rot[i] = req[LVL_W'(lp + LVL_W'(i) + 3'd1)];
  end

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = LVL_W'(i);
      end
    end
  end

  assign level = lp + off + 3'd1;

endmodule

// File: rtl/pic_inta_sequencer.sv
// INTA sequencer: raises INT, resolves the winner, owns the ISR, runs the
// two-pulse 8086 acknowledge and executes OCW2 EOI/rotation commands.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter logic [LVL_W-1:0] RESET_LP = 3'd7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] irr,
  input  logic [NUM_LEVELS-1:0] imr,
  input  logic                  inta_n,
  input  logic [4:0]            icw2_base,
  input  logic                  aeoi,
  input  logic                  ocw2_valid,
  input  logic [2:0]            ocw2_cmd,
  input  logic [LVL_W-1:0]      ocw2_level,
  output logic                  int_o,
  output logic [NUM_LEVELS-1:0] isr,
  output logic [NUM_LEVELS-1:0] irr_clr,
  output logic [7:0]            vec_out,
  output logic                  vec_oe
);

  state_t                state, state_nxt;
  logic                  inta_q, fall, rise;
  logic [LVL_W-1:0]      lp, lp_nxt, lvl, lvl_nxt;
  logic                  spur, spur_nxt;
  logic                  int_nxt, vec_oe_nxt;
  logic [7:0]            vec_out_nxt;
  logic [NUM_LEVELS-1:0] elig, isr_set, aeoi_clr, ocw_clr, irr_clr_nxt, isr_nxt;
  logic                  req_vld, isr_vld, pending;
  logic [LVL_W-1:0]      req_lvl, isr_lvl;

  assign elig = irr & ~imr;
  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

  pic_priority_resolver u_req_res (.req(elig), .lp(lp), .valid(req_vld), .level(req_lvl));
  pic_priority_resolver u_isr_res (.req(isr),  .lp(lp), .valid(isr_vld), .level(isr_lvl));

  assign pending = req_vld &&
                   (!isr_vld || (prio_rank(req_lvl, lp) < prio_rank(isr_lvl, lp)));

  always_comb begin
    state_nxt   = state;
    int_nxt     = 1'b0;
    vec_oe_nxt  = vec_oe;
    vec_out_nxt = vec_out;
    lvl_nxt     = lvl;
    spur_nxt    = spur;
    isr_set     = '0;
    aeoi_clr    = '0;
    irr_clr_nxt = '0;
    case (state)
      IDLE: begin
        int_nxt    = pending;
        vec_oe_nxt = 1'b0;
        if (fall) begin
          int_nxt   = 1'b0;
          state_nxt = ACK1;
          if (req_vld) begin
            isr_set     = onehot(req_lvl);
            irr_clr_nxt = onehot(req_lvl);
            lvl_nxt     = req_lvl;
            spur_nxt    = 1'b0;
          end else begin
            // nothing eligible any more: answer with the level-7 vector
            lvl_nxt  = 3'd7;
            spur_nxt = 1'b1;
          end
        end
      end
      ACK1: begin
        if (fall) begin
          state_nxt   = ACK2;
          vec_oe_nxt  = 1'b1;
          vec_out_nxt = {icw2_base, lvl};
        end
      end
      ACK2: begin
        if (rise) begin
          state_nxt  = IDLE;
          vec_oe_nxt = 1'b0;
          if (aeoi && !spur) aeoi_clr = onehot(lvl);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // OCW2 acts in every state; a same-cycle INTA set overrides its clear
  always_comb begin
    ocw_clr = '0;
    lp_nxt  = lp;
    if (ocw2_valid) begin
      case (ocw2_cmd)
        EOI_NS: if (isr_vld) ocw_clr = onehot(isr_lvl);
        EOI_SP: ocw_clr = onehot(ocw2_level);
        ROT_NS: if (isr_vld) begin
          ocw_clr = onehot(isr_lvl);
          lp_nxt  = isr_lvl;
        end
        ROT_SP: begin
          ocw_clr = onehot(ocw2_level);
          lp_nxt  = ocw2_level;
        end
        SET_PRI: lp_nxt = ocw2_level;
        default: ;
      endcase
    end
  end

  assign isr_nxt = (isr & ~(ocw_clr | aeoi_clr)) | isr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      inta_q  <= 1'b1;
      isr     <= '0;
      int_o   <= 1'b0;
      irr_clr <= '0;
      vec_oe  <= 1'b0;
      vec_out <= '0;
      lp      <= RESET_LP;
      lvl     <= '0;
      spur    <= 1'b0;
    end else begin
      state   <= state_nxt;
      inta_q  <= inta_n;
      isr     <= isr_nxt;
      int_o   <= int_nxt;
      irr_clr <= irr_clr_nxt;
      vec_oe  <= vec_oe_nxt;
      vec_out <= vec_out_nxt;
      lp      <= lp_nxt;
      lvl     <= lvl_nxt;
      spur    <= spur_nxt;
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed scenarios plus random traffic checked
// against a transaction-level model of ISR, priority and vectors.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic       inta_n;
  logic [4:0] icw2_base;
  logic       aeoi;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       int_o;
  logic [7:0] isr, irr_clr, vec_out;
  logic       vec_oe;

  pic_inta_sequencer dut (
    .clk(clk), .reset(reset), .irr(irr), .imr(imr), .inta_n(inta_n),
    .icw2_base(icw2_base), .aeoi(aeoi), .ocw2_valid(ocw2_valid),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .int_o(int_o), .isr(isr),
    .irr_clr(irr_clr), .vec_out(vec_out), .vec_oe(vec_oe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [7:0] m_isr;
  int         m_lp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_rank(input int l);
    return (l - m_lp - 1 + 16) % 8;
  endfunction

  // walk levels in priority order starting after lp
  function automatic int m_highest(input logic [7:0] v);
    for (int r = 0; r < 8; r++) begin
      int l;
      l = (m_lp + 1 + r) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic m_pending();
    int he, hi;
    he = m_highest(irr & ~imr);
    hi = m_highest(m_isr);
    return (he >= 0) && (hi < 0 || m_rank(he) < m_rank(hi));
  endfunction

  task automatic check_idle(input string tag);
    tick();
    tick();
    chk({tag, "_int"}, int_o, m_pending());
    chk({tag, "_isr"}, isr, m_isr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_isr = 8'h00;
    m_lp  = 7;
  endtask

  task automatic ocw2(input logic [2:0] c, input logic [2:0] l);
    int h;
    ocw2_valid = 1'b1;
    ocw2_cmd   = c;
    ocw2_level = l;
    tick();
    ocw2_valid = 1'b0;
    h = m_highest(m_isr);
    case (c)
      3'b001: if (h >= 0) m_isr[h] = 1'b0;
      3'b011: m_isr[l] = 1'b0;
      3'b101: if (h >= 0) begin m_isr[h] = 1'b0; m_lp = h; end
      3'b111: begin m_isr[l] = 1'b0; m_lp = int'(l); end
      3'b110: m_lp = int'(l);
      default: ;
    endcase
    chk("ocw2_isr", isr, m_isr);
  endtask

  // full two-pulse acknowledge; returns the acknowledged level and the vector seen
  task automatic inta_cycle(output logic [2:0] lo, output logic [7:0] vo);
    int w, wid;
    logic spur;
    w    = m_highest(irr & ~imr);
    spur = (w < 0);
    lo   = spur ? 3'd7 : 3'(w);
    wid  = $urandom_range(0, 1);
    inta_n = 1'b0;
    tick();
    if (!spur) m_isr[w] = 1'b1;
    chk("ack_isr", isr, m_isr);
    chk("ack_irr_clr", irr_clr, spur ? 8'h00 : (8'h01 << lo));
    chk("ack_int_lo", int_o, 1'b0);
    chk("p1_vec_oe", vec_oe, 1'b0);
    repeat (wid) tick();
    inta_n = 1'b1;
    tick();
    chk("irr_clr_1cyc", irr_clr, 8'h00);
    chk("hold_int", int_o, 1'b0);
    if (!spur) irr[w] = 1'b0;
    inta_n = 1'b0;
    tick();
    vo = vec_out;
    chk("p2_vec_oe", vec_oe, 1'b1);
    chk("p2_vec", vec_out, {icw2_base, lo});
    repeat (wid) tick();
    chk("p2_vec_oe_hold", vec_oe, 1'b1);
    inta_n = 1'b1;
    tick();
    if (aeoi && !spur) m_isr[lo] = 1'b0;
    chk("end_vec_oe", vec_oe, 1'b0);
    chk("end_isr", isr, m_isr);
  endtask

  logic [2:0] l;
  logic [7:0] v;

  initial begin
    irr = 8'h00; imr = 8'h00; inta_n = 1'b1; icw2_base = 5'b01000; aeoi = 1'b0;
    ocw2_valid = 1'b0; ocw2_cmd = 3'b000; ocw2_level = 3'd0; reset = 1'b1;
    tick();
    do_reset();
    chk("rst_int", int_o, 1'b0);
    chk("rst_isr", isr, 8'h00);
    chk("rst_irr_clr", irr_clr, 8'h00);
    chk("rst_vec_oe", vec_oe, 1'b0);
    chk("rst_vec", vec_out, 8'h00);

    // basic acknowledge
    irr = 8'h04;
    check_idle("t1");
    chk("t1_int1", int_o, 1'b1);
    inta_cycle(l, v);
    chk("t1_lvl", l, 3'd2);
    chk("t1_vec", v, 8'h42);
    chk("t1_isr", isr, 8'h04);

    // nesting and EOI
    irr = 8'h01;
    check_idle("t2");
    chk("t2_int1", int_o, 1'b1);
    inta_cycle(l, v);
    chk("t2_isr", isr, 8'h05);
    irr = 8'h08;
    check_idle("t2b");
    chk("t2_blocked", int_o, 1'b0);
    ocw2(3'b001, 3'd0);
    chk("t2_eoi", isr, 8'h04);
    ocw2(3'b001, 3'd0);
    irr = 8'h00;
    check_idle("t2c");

    // rotation
    irr = 8'h10;
    check_idle("t3");
    inta_cycle(l, v);
    chk("t3_isr", isr, 8'h10);
    ocw2(3'b101, 3'd0);
    chk("t3_rot_isr", isr, 8'h00);
    irr = 8'h21;
    check_idle("t3b");
    chk("t3_int1", int_o, 1'b1);
    inta_cycle(l, v);
    chk("t3_lvl", l, 3'd5);
    chk("t3_vec", v, 8'h45);
    ocw2(3'b011, 3'd5);
    ocw2(3'b110, 3'd7);
    irr = 8'h00;

    // AEOI and mask
    aeoi = 1'b1; imr = 8'h02; irr = 8'h03;
    check_idle("t4");
    inta_cycle(l, v);
    chk("t4_lvl", l, 3'd0);
    chk("t4_isr", isr, 8'h00);
    check_idle("t4b");
    chk("t4_masked", int_o, 1'b0);
    aeoi = 1'b0; imr = 8'h00; irr = 8'h00;

    // spurious
    irr = 8'h80;
    check_idle("t5");
    chk("t5_int1", int_o, 1'b1);
    irr = 8'h00;
    inta_cycle(l, v);
    chk("t5_vec", v, 8'h47);
    chk("t5_isr", isr, 8'h00);

    // reset in ACK1, then a normal acknowledge proves the FSM is back in IDLE
    irr = 8'h04;
    check_idle("t6");
    inta_n = 1'b0;
    tick();
    chk("t6_isr_set", isr, 8'h04);
    inta_n = 1'b1;
    do_reset();
    chk("t6_isr", isr, 8'h00);
    chk("t6_vec_oe", vec_oe, 1'b0);
    chk("t6_int", int_o, 1'b0);
    chk("t6_irr_clr", irr_clr, 8'h00);
    check_idle("t6b");
    inta_cycle(l, v);
    chk("t6_lvl", l, 3'd2);

    // same-cycle specific EOI and INTA set of level 2
    irr = 8'h04;
    inta_n = 1'b0;
    ocw2_valid = 1'b1; ocw2_cmd = 3'b011; ocw2_level = 3'd2;
    tick();
    ocw2_valid = 1'b0;
    chk("t7_setclr", isr, 8'h04);
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("t7_vec", vec_out, 8'h42);
    inta_n = 1'b1; tick();
    irr = 8'h00;
    ocw2(3'b011, 3'd2);
    chk("t7_clean", isr, 8'h00);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        irr  = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
        imr  = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
        aeoi = ($urandom_range(0, 4) == 0);
        check_idle("rnd_in");
      end else if (r < 7) begin
        inta_cycle(l, v);
        check_idle("rnd_ack");
      end else begin
        ocw2(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        check_idle("rnd_ocw");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
